// File: rtl/handshake_arbiter.sv
// Round-robin scheduler sharing one cross-clock handshake among N requesters.
// Each requester's payload is buffered until its turn. The grant then holds
// payload and owner steady until the handshake's busy drops or the
// transaction times out.
module handshake_arbiter #(
    parameter int N           = 4,
    parameter int WIDTH       = 8,
    parameter int OWNER_WIDTH = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N-1:0]           request,
    input  logic [N*WIDTH-1:0]     data_in,
    input  logic                   hs_busy,
    output logic                   hs_trigger,
    output logic [WIDTH-1:0]       hs_data,
    output logic [OWNER_WIDTH-1:0] hs_owner,
    output logic [N-1:0]           pending,
    output logic [N-1:0]           done,
    output logic [N-1:0]           overflow,
    output logic                   timeout_error
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

    state_t                 state;
    state_t                 state_next;
    logic [OWNER_WIDTH-1:0] last_grant;
    logic [WIDTH-1:0]       held [N];
    logic [15:0]            cycle_cnt;
    logic [15:0]            cnt_inc;
    logic                   timeout_hit;

    logic                   lo_found;
    logic                   hi_found;
    logic [OWNER_WIDTH-1:0] lo_idx;
    logic [OWNER_WIDTH-1:0] hi_idx;
    logic                   win_found;
    logic [OWNER_WIDTH-1:0] win_idx;

    logic                   grant;
    logic                   complete;
    logic                   abort;
    logic [N-1:0]           fin_mask;
    logic [N-1:0]           pend_kept;
    logic [N-1:0]           capture;

    // The counter saturates so a stuck transaction cannot wrap back under the limit.
    assign cnt_inc     = (cycle_cnt == 16'hFFFF) ? cycle_cnt : cycle_cnt + 16'd1;
    assign timeout_hit = (cnt_inc >= TIMEOUT_C);

    // Round-robin pick: the lowest pending index above last_grant, else the lowest pending index overall.
    always_comb begin
        lo_found = 1'b0;
        hi_found = 1'b0;
        lo_idx   = '0;
        hi_idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (pending[i] && !lo_found) begin
                lo_found = 1'b1;
                lo_idx   = OWNER_WIDTH'(i);
            end
            if (pending[i] && !hi_found && (i > int'(last_grant))) begin
                hi_found = 1'b1;
                hi_idx   = OWNER_WIDTH'(i);
            end
        end
        win_found = lo_found;
        win_idx   = hi_found ? hi_idx : lo_idx;
    end

    // Next-state logic. Completion takes priority over a timeout on the same edge.
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        complete   = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (win_found && !hs_busy) begin
                    grant      = 1'b1;
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                state_next = WAIT_HIGH;
            end
            WAIT_HIGH: begin
                if (timeout_hit) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end else if (hs_busy) begin
                    state_next = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (!hs_busy) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end else if (timeout_hit) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Clearing the finishing owner before capture lets a same-cycle re-request be accepted.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            fin_mask[i] = (complete || abort) && (hs_owner == OWNER_WIDTH'(i));
        end
        pend_kept = pending & ~fin_mask;
        capture   = request & ~pend_kept;
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Control registers: pending set, strobes, grant history and transaction counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_grant    <= OWNER_WIDTH'(N - 1);
            pending       <= '0;
            done          <= '0;
            overflow      <= '0;
            timeout_error <= 1'b0;
            hs_trigger    <= 1'b0;
            cycle_cnt     <= '0;
        end else begin
            pending       <= pend_kept | request;
            overflow      <= request & pend_kept;
            done          <= complete ? fin_mask : '0;
            timeout_error <= abort;
            hs_trigger    <= grant;
            if (complete || abort) begin
                last_grant <= hs_owner;
            end
            if (grant) begin
                cycle_cnt <= '0;
            end else if (state == WAIT_HIGH || state == WAIT_LOW) begin
                cycle_cnt <= cnt_inc;
            end
        end
    end

    // Payload and owner presented to the handshake; only a new grant changes them.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hs_data  <= '0;
            hs_owner <= '0;
        end else if (grant) begin
            hs_data  <= held[win_idx];
            hs_owner <= win_idx;
        end
    end

    // Per-requester payload buffers, loaded only when a request is accepted.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                held[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (capture[i]) begin
                    held[i] <= data_in[i*WIDTH +: WIDTH];
                end
            end
        end
    end

endmodule

// File: tb/tb_handshake_arbiter.sv
// Directed bench for handshake_arbiter: N=4, WIDTH=8, TIMEOUT=20.
module tb_handshake_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  request;
    logic [31:0] data_in;
    logic        hs_busy;
    logic        hs_trigger;
    logic [7:0]  hs_data;
    logic [1:0]  hs_owner;
    logic [3:0]  pending;
    logic [3:0]  done;
    logic [3:0]  overflow;
    logic        timeout_error;

    int vectors    = 0;
    int miscompares = 0;

    handshake_arbiter #(
        .N           (4),
        .WIDTH       (8),
        .OWNER_WIDTH (2),
        .TIMEOUT     (20)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .request       (request),
        .data_in       (data_in),
        .hs_busy       (hs_busy),
        .hs_trigger    (hs_trigger),
        .hs_data       (hs_data),
        .hs_owner      (hs_owner),
        .pending       (pending),
        .done          (done),
        .overflow      (overflow),
        .timeout_error (timeout_error)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for the trigger, then checks the granted owner and payload.
    task automatic wait_grant(input logic [1:0] owner, input logic [7:0] data);
        int n;
        n = 0;
        while (hs_trigger !== 1'b1 && n < 16) begin
            step();
            n++;
        end
        check("grant_trigger", {31'd0, hs_trigger}, 32'd1);
        check("grant_owner", {30'd0, hs_owner}, {30'd0, owner});
        check("grant_data", {24'd0, hs_data}, {24'd0, data});
    endtask

    // Called on the LAUNCH cycle: leaves LAUNCH, drives busy for busy_len edges, checks done.
    task automatic finish_txn(input logic [1:0] owner, input int busy_len);
        logic [3:0] onehot;
        onehot = 4'b0001 << owner;
        step();
        check("trigger_fall", {31'd0, hs_trigger}, 32'd0);
        check("no_overflow", {28'd0, overflow}, 32'd0);
        hs_busy = 1'b1;
        repeat (busy_len) step();
        check("done_while_busy", {28'd0, done}, 32'd0);
        hs_busy = 1'b0;
        step();
        check("done_pulse", {28'd0, done}, {28'd0, onehot});
        check("pending_cleared", {28'd0, pending & onehot}, 32'd0);
        step();
        check("done_one_cycle", {28'd0, done}, 32'd0);
    endtask

    initial begin
        logic       seen;
        reset   = 1'b0;
        request = 4'b0000;
        data_in = 32'd0;
        hs_busy = 1'b0;
        step();
        step();
        check("reset_outputs",
              {8'd0, hs_trigger, hs_data, hs_owner, pending, done, overflow, timeout_error}, 32'd0);
        reset = 1'b1;
        step();

        // Single request on 0: trigger two edges after the request.
        request = 4'b0001;
        data_in = 32'h0000_00A5;
        step();
        check("single_pending", {28'd0, pending}, 32'h1);
        check("single_no_trigger_yet", {31'd0, hs_trigger}, 32'd0);
        request = 4'b0000;
        step();
        check("single_trigger", {31'd0, hs_trigger}, 32'd1);
        check("single_data", {24'd0, hs_data}, 32'hA5);
        check("single_owner", {30'd0, hs_owner}, 32'd0);
        finish_txn(2'd0, 10);

        // Fresh reset so requester 0 is first in the round-robin sweep.
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();

        request = 4'b1111;
        data_in = 32'h1312_1110;
        step();
        check("rr_pending_all", {28'd0, pending}, 32'hF);
        request = 4'b0000;
        wait_grant(2'd0, 8'h10);
        finish_txn(2'd0, 10);
        wait_grant(2'd1, 8'h11);
        finish_txn(2'd1, 10);
        wait_grant(2'd2, 8'h12);
        finish_txn(2'd2, 10);
        wait_grant(2'd3, 8'h13);
        finish_txn(2'd3, 10);
        check("rr_pending_empty", {28'd0, pending}, 32'd0);

        // last_grant is 3, so 0 beats 3.
        request = 4'b1001;
        data_in = 32'hD300_00D0;
        step();
        request = 4'b0000;
        wait_grant(2'd0, 8'hD0);
        finish_txn(2'd0, 10);
        wait_grant(2'd3, 8'hD3);
        finish_txn(2'd3, 10);

        // Overflow on 2: second request lands on the grant edge and is rejected.
        request = 4'b0100;
        data_in = 32'h0055_0000;
        step();
        check("ovf_pending", {28'd0, pending}, 32'h4);
        check("ovf_none_yet", {28'd0, overflow}, 32'd0);
        data_in = 32'h0066_0000;
        step();
        check("ovf_pulse", {28'd0, overflow}, 32'h4);
        check("ovf_trigger", {31'd0, hs_trigger}, 32'd1);
        check("ovf_data_kept", {24'd0, hs_data}, 32'h55);
        request = 4'b0000;
        finish_txn(2'd2, 10);

        // Timeout: 3 wins (last_grant 2), busy never rises; then 1 launches.
        request = 4'b1010;
        data_in = 32'h9900_4400;
        step();
        request = 4'b0000;
        wait_grant(2'd3, 8'h99);
        step();
        check("to_left_launch", {31'd0, hs_trigger}, 32'd0);
        repeat (19) step();
        check("to_not_yet", {31'd0, timeout_error}, 32'd0);
        step();
        check("to_pulse", {31'd0, timeout_error}, 32'd1);
        check("to_pending", {28'd0, pending}, 32'h2);
        check("to_no_done", {28'd0, done}, 32'd0);
        step();
        check("to_one_cycle", {31'd0, timeout_error}, 32'd0);
        check("to_next_trigger", {31'd0, hs_trigger}, 32'd1);
        check("to_next_owner", {30'd0, hs_owner}, 32'd1);
        check("to_next_data", {24'd0, hs_data}, 32'h44);
        finish_txn(2'd1, 3);

        // Reset during WAIT_LOW with 0 and 2 pending.
        request = 4'b0101;
        data_in = 32'h0033_0022;
        step();
        request = 4'b0000;
        wait_grant(2'd2, 8'h33);
        step();
        hs_busy = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        check("midreset_outputs",
              {8'd0, hs_trigger, hs_data, hs_owner, pending, done, overflow, timeout_error}, 32'd0);
        hs_busy = 1'b0;
        step();
        step();
        reset = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            step();
            seen = seen | hs_trigger | (|done) | timeout_error | (|pending);
        end
        check("midreset_quiet", {31'd0, seen}, 32'd0);

        // After reset, last_grant is back to 3, so 0 goes before 2.
        request = 4'b0101;
        data_in = 32'h00BB_00AA;
        step();
        request = 4'b0000;
        wait_grant(2'd0, 8'hAA);
        finish_txn(2'd0, 10);
        wait_grant(2'd2, 8'hBB);
        finish_txn(2'd2, 10);

        // Re-request on 1 in its completion cycle.
        request = 4'b0010;
        data_in = 32'h0000_1100;
        step();
        request = 4'b0000;
        wait_grant(2'd1, 8'h11);
        step();
        hs_busy = 1'b1;
        repeat (10) step();
        hs_busy = 1'b0;
        request = 4'b0010;
        data_in = 32'h0000_7700;
        step();
        request = 4'b0000;
        check("rereq_done", {28'd0, done}, 32'h2);
        check("rereq_pending", {28'd0, pending}, 32'h2);
        check("rereq_no_overflow", {28'd0, overflow}, 32'd0);
        wait_grant(2'd1, 8'h77);
        finish_txn(2'd1, 10);
        check("final_pending", {28'd0, pending}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/handshake_arbiter.md
# handshake_arbiter

Round-robin scheduler that shares one cross-clock `handshake` instance among N requesters in the launching clock domain. It captures a payload word per requester and holds it in a per-requester buffer. It then grants the handshake to one requester at a time, drives a one-cycle trigger, and holds the payload and owner index stable until the handshake's `busy` drops. Completion, overflow and timeout are reported per transaction.

## Interface
- `N`, 4: number of requesters (2..16).
- `WIDTH`, 8: payload width.
- `OWNER_WIDTH`, 2: width of owner index; must satisfy 2^OWNER_WIDTH >= N.
- `TIMEOUT`, 255: maximum cycles from trigger to end of transaction (1..65535).

- `clock`  in  1  sole clock; all logic on posedge.
- `reset`  in  1  asynchronous, active-low; asserted (0) clears all state immediately.
- `request`  in  N  per-requester single-cycle request strobe.
- `data_in`  in  N*WIDTH  payloads; requester i uses bits [i*WIDTH +: WIDTH], sampled with `request[i]`.
- `hs_busy`  in  1  `busy` from the shared handshake.
- `hs_trigger`  out  1  one-cycle pulse to the handshake's `input_trigger_a`.
- `hs_data`  out  WIDTH  payload of the current owner, stable for the whole transaction.
- `hs_owner`  out  OWNER_WIDTH  index of the current owner.
- `pending`  out  N  requester has a buffered, unfinished transaction.
- `done`  out  N  one-cycle pulse when the requester's transaction completes.
- `overflow`  out  N  one-cycle pulse when a request is rejected.
- `timeout_error`  out  1  one-cycle pulse when a transaction is aborted.

## Operation
- **Capture:** `request[i]` with `pending[i]`=0 sets `pending[i]` and loads `held[i]` from `data_in`.
- **Rejection:** `request[i]` with `pending[i]`=1 (and no same-cycle completion for i) pulses `overflow[i]`. `held[i]` is unchanged.
- **FSM states:** IDLE, LAUNCH, WAIT_HIGH, WAIT_LOW.
- **IDLE:** if `pending`!=0 and `hs_busy`=0, choose winner w:
  - w is the first pending index scanning from (last_grant+1) mod N upward with wraparound.
  - Load `hs_data`<=`held[w]`, `hs_owner`<=w, clear cycle counter, go to LAUNCH.
- **LAUNCH:** `hs_trigger`=1 for this cycle only; go to WAIT_HIGH.
- **WAIT_HIGH:** on `hs_busy`=1 go to WAIT_LOW.
- **WAIT_LOW:** on `hs_busy`=0:
  - Pulse `done[w]`, clear `pending[w]`, last_grant<=w, go to IDLE.
- **Timeout:** the counter increments in WAIT_HIGH and WAIT_LOW and saturates. When it reaches TIMEOUT before completion:
  - Pulse `timeout_error`, clear `pending[w]`, last_grant<=w, go to IDLE.
  - No `done` pulse.
- **Fixed grant:** once granted, `hs_data` and `hs_owner` do not change until the next grant. New requests never preempt.
- **Same-cycle request and completion:** `request[w]` in the same cycle as w's completion or timeout re-captures the request. Set wins: `pending[w]` stays 1, `held[w]` gets the new data, no overflow. Requester w goes to lowest priority.
- **Multiple requests:** simultaneous requests on several indices are all captured independently.

## Timing
- **Reset values (while `reset`=0):**
  - state=IDLE, last_grant=N-1 (requester 0 wins first).
  - `pending`=0, `held`=0, `hs_trigger`=0, `hs_data`=0, `hs_owner`=0.
  - `done`=0, `overflow`=0, `timeout_error`=0, counter=0.
- **Reset mid-transaction:** all pending work is dropped and no `done` or `timeout_error` is emitted.
- **Registered outputs:** all outputs are registered; there are no combinational paths from inputs.
- **Request to trigger:** `request` sampled at edge k gives `pending` high after k. The grant is made at edge k+1, with `hs_trigger`, `hs_data` and `hs_owner` valid after k+1. The trigger falls after k+2.
- **Completion:** `hs_busy` sampled low in WAIT_LOW at edge m gives `done` high after m. The next grant can occur at edge m+1, provided `hs_busy` is still 0.
- **Trigger spacing:** minimum 4 cycles between triggers.
- **Strobe widths:** `overflow` and `timeout_error` are each high for exactly one cycle.
- **Launch condition:** IDLE never launches while `hs_busy`=1, including busy left over from an external source.

## Test plan
- **Single request:** N=4, `request`=0001, `data_in[7:0]`=0xA5; bench models busy as high 1 cycle after trigger for 10 cycles -> `hs_trigger` pulses 2 edges after the request, `hs_data`=0xA5, `hs_owner`=0, `done`=0001 one cycle after busy falls.
- **Round-robin:** all four request at once with payloads 0x10..0x13 -> four triggers in order owners 0,1,2,3, matching payloads, four `done` pulses. A following request on 0 and 3 together serves 0 first (last_grant=3).
- **Overflow:** `request[2]` with data 0x55, then `request[2]` again with 0x66 while pending -> `overflow`=0100 for one cycle; transaction carries 0x55.
- **Timeout:** TIMEOUT=20, `hs_busy` held at 0 after trigger -> `timeout_error` pulses 20 cycles after leaving LAUNCH, `pending[w]` cleared, no `done`, next pending requester launches.
- **Reset mid-transaction:** drive `reset`=0 during WAIT_LOW with two requests pending -> all outputs 0 immediately. After release, no trigger until a new request.
- **Same-cycle re-request:** `request[1]` with 0x77 in the cycle `done[1]` would pulse -> `done[1]` pulses, `pending[1]` remains 1, no overflow, next transaction for 1 carries 0x77.
